// File: rtl/sum_accum.sv
// Frame accumulator downstream of sum: adds an in_last-delimited frame of DTYPE
// beats into one total and presents it with its beat count on a valid/ready output.
module sum_accum #(
  parameter type DTYPE   = int,
  parameter int  MAX_LEN = 16,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  DTYPE          in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output DTYPE          out_data,
  output logic [CW-1:0] out_count,
  output logic          out_trunc
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_nxt;
  DTYPE          acc;
  DTYPE          acc_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          take;

  // HOLD is the only state that refuses beats, so input and output handshakes never overlap.
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign take      = in_valid && in_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    if (take) begin
      if (state == IDLE) begin
        acc_nxt = in_data;
        cnt_nxt = CW'(1);
      end else begin
        acc_nxt = acc + in_data;
        cnt_nxt = cnt + CW'(1);
      end
      state_nxt = (in_last || (cnt_nxt == CW'(MAX_LEN))) ? HOLD : ACCUM;
    end else if ((state == HOLD) && out_ready) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= DTYPE'(0);
      cnt       <= '0;
      out_data  <= DTYPE'(0);
      out_count <= '0;
      out_trunc <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      // Capture only on the HOLD entry so the presented total stays frozen until handshake.
      if (take && (state_nxt == HOLD)) begin
        out_data  <= acc_nxt;
        out_count <= cnt_nxt;
        out_trunc <= !in_last;
      end
    end
  end

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum: int, floating-point, 4-bit wrap and MAX_LEN=4
// instances, with hand-computed totals, counts and truncation flags.
module tb_sum_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // int instance, MAX_LEN=16
  logic       i_valid = 0, i_ready, i_last = 0, i_ovalid, i_oready = 0, i_otrunc;
  int         i_data = 0, i_odata;
  logic [4:0] i_ocount;
  // floating-point instance; all test values are exact in single precision
  logic       r_valid = 0, r_ready, r_last = 0, r_ovalid, r_oready = 0, r_otrunc;
  real        r_data = 0.0, r_odata;
  logic [4:0] r_ocount;
  // 4-bit instance
  logic       n_valid = 0, n_ready, n_last = 0, n_ovalid, n_oready = 0, n_otrunc;
  logic [3:0] n_data = 0, n_odata;
  logic [4:0] n_ocount;
  // int instance, MAX_LEN=4
  logic       t_valid = 0, t_ready, t_last = 0, t_ovalid, t_oready = 0, t_otrunc;
  int         t_data = 0, t_odata;
  logic [2:0] t_ocount;

  sum_accum #(.DTYPE(int), .MAX_LEN(16)) u_int (
    .clk(clk), .rst_n(rst_n), .in_valid(i_valid), .in_ready(i_ready), .in_data(i_data),
    .in_last(i_last), .out_valid(i_ovalid), .out_ready(i_oready), .out_data(i_odata),
    .out_count(i_ocount), .out_trunc(i_otrunc));

  sum_accum #(.DTYPE(real), .MAX_LEN(16)) u_real (
    .clk(clk), .rst_n(rst_n), .in_valid(r_valid), .in_ready(r_ready), .in_data(r_data),
    .in_last(r_last), .out_valid(r_ovalid), .out_ready(r_oready), .out_data(r_odata),
    .out_count(r_ocount), .out_trunc(r_otrunc));

  sum_accum #(.DTYPE(logic [3:0]), .MAX_LEN(16)) u_nib (
    .clk(clk), .rst_n(rst_n), .in_valid(n_valid), .in_ready(n_ready), .in_data(n_data),
    .in_last(n_last), .out_valid(n_ovalid), .out_ready(n_oready), .out_data(n_odata),
    .out_count(n_ocount), .out_trunc(n_otrunc));

  sum_accum #(.DTYPE(int), .MAX_LEN(4)) u_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(t_valid), .in_ready(t_ready), .in_data(t_data),
    .in_last(t_last), .out_valid(t_ovalid), .out_ready(t_oready), .out_data(t_odata),
    .out_count(t_ocount), .out_trunc(t_otrunc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_int(input int d, input logic last);
    i_valid = 1; i_data = d; i_last = last;
    tick();
    i_valid = 0; i_last = 0;
  endtask

  task automatic beat_real(input real d, input logic last);
    r_valid = 1; r_data = d; r_last = last;
    tick();
    r_valid = 0; r_last = 0;
  endtask

  task automatic beat_nib(input logic [3:0] d, input logic last);
    n_valid = 1; n_data = d; n_last = last;
    tick();
    n_valid = 0; n_last = 0;
  endtask

  task automatic beat_trunc(input int d, input logic last);
    t_valid = 1; t_data = d; t_last = last;
    tick();
    t_valid = 0; t_last = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    checks++; if (i_ovalid !== 1'b0) $display("FAIL reset_ovalid got %0b want 0", i_ovalid); else passes++;
    checks++; if (i_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", i_ready); else passes++;
    checks++; if (i_odata !== 0) $display("FAIL reset_odata got %0d want 0", i_odata); else passes++;
    checks++; if (i_ocount !== 5'd0) $display("FAIL reset_ocount got %0d want 0", i_ocount); else passes++;
    checks++; if (i_otrunc !== 1'b0) $display("FAIL reset_otrunc got %0b want 0", i_otrunc); else passes++;
    checks++; if (t_ready !== 1'b1 || t_ovalid !== 1'b0) $display("FAIL reset_trunc_inst got ready=%0b valid=%0b want 1/0", t_ready, t_ovalid); else passes++;
    checks++; if (r_odata != 0.0) $display("FAIL reset_real_odata got %f want 0.0", r_odata); else passes++;
  endtask

  task automatic test_int_frame();
    i_oready = 1;
    beat_int(2, 0);
    checks++; if (i_ovalid !== 1'b0 || i_ready !== 1'b1) $display("FAIL int_open got valid=%0b ready=%0b want 0/1", i_ovalid, i_ready); else passes++;
    beat_int(-5, 0);
    beat_int(7, 1);
    checks++; if (i_ovalid !== 1'b1) $display("FAIL int_ovalid got %0b want 1", i_ovalid); else passes++;
    checks++; if (i_ready !== 1'b0) $display("FAIL int_ready_hold got %0b want 0", i_ready); else passes++;
    checks++; if (i_odata !== 4) $display("FAIL int_odata got %0d want 4", i_odata); else passes++;
    checks++; if (i_ocount !== 5'd3) $display("FAIL int_ocount got %0d want 3", i_ocount); else passes++;
    checks++; if (i_otrunc !== 1'b0) $display("FAIL int_otrunc got %0b want 0", i_otrunc); else passes++;
    tick();
    checks++; if (i_ovalid !== 1'b0 || i_ready !== 1'b1) $display("FAIL int_handshake got valid=%0b ready=%0b want 0/1", i_ovalid, i_ready); else passes++;
  endtask

  task automatic test_real_frame();
    r_oready = 1;
    beat_real(1.0, 0);
    beat_real(2.5, 1);
    checks++; if (r_ovalid !== 1'b1 || r_odata != 3.5) $display("FAIL real_sum got valid=%0b data=%f want 1/3.5", r_ovalid, r_odata); else passes++;
    checks++; if (r_ocount !== 5'd2) $display("FAIL real_count got %0d want 2", r_ocount); else passes++;
    tick();
    beat_real(-0.75, 1);
    checks++; if (r_ovalid !== 1'b1 || r_odata != -0.75) $display("FAIL real_single got valid=%0b data=%f want 1/-0.75", r_ovalid, r_odata); else passes++;
    checks++; if (r_ocount !== 5'd1 || r_otrunc !== 1'b0) $display("FAIL real_single_count got %0d trunc=%0b want 1/0", r_ocount, r_otrunc); else passes++;
    tick();
  endtask

  task automatic test_wrap();
    n_oready = 1;
    beat_nib(4'd10, 0);
    beat_nib(4'd8, 1);
    checks++; if (n_ovalid !== 1'b1 || n_odata !== 4'd2) $display("FAIL wrap_two got valid=%0b data=%0d want 1/2", n_ovalid, n_odata); else passes++;
    checks++; if (n_ocount !== 5'd2) $display("FAIL wrap_two_count got %0d want 2", n_ocount); else passes++;
    tick();
    beat_nib(4'd15, 0);
    beat_nib(4'd15, 0);
    beat_nib(4'd15, 1);
    checks++; if (n_ovalid !== 1'b1 || n_odata !== 4'd13) $display("FAIL wrap_three got valid=%0b data=%0d want 1/13", n_ovalid, n_odata); else passes++;
    checks++; if (n_ocount !== 5'd3) $display("FAIL wrap_three_count got %0d want 3", n_ocount); else passes++;
    tick();
  endtask

  task automatic test_trunc();
    t_oready = 1;
    for (int k = 1; k <= 4; k++) beat_trunc(k, 0);
    checks++; if (t_ovalid !== 1'b1 || t_odata !== 10) $display("FAIL trunc_sum got valid=%0b data=%0d want 1/10", t_ovalid, t_odata); else passes++;
    checks++; if (t_ocount !== 3'd4 || t_otrunc !== 1'b1) $display("FAIL trunc_flag got count=%0d trunc=%0b want 4/1", t_ocount, t_otrunc); else passes++;
    checks++; if (t_ready !== 1'b0) $display("FAIL trunc_ready got %0b want 0", t_ready); else passes++;
    // Beat 5 is offered during HOLD and must wait out the handshake edge.
    t_valid = 1; t_data = 5; t_last = 1;
    tick();
    checks++; if (t_ovalid !== 1'b0 || t_ready !== 1'b1) $display("FAIL trunc_handshake got valid=%0b ready=%0b want 0/1", t_ovalid, t_ready); else passes++;
    tick();
    t_valid = 0; t_last = 0;
    checks++; if (t_ovalid !== 1'b1 || t_odata !== 5 || t_ocount !== 3'd1) $display("FAIL trunc_beat5 got valid=%0b data=%0d count=%0d want 1/5/1", t_ovalid, t_odata, t_ocount); else passes++;
    checks++; if (t_otrunc !== 1'b0) $display("FAIL trunc_beat5_flag got %0b want 0", t_otrunc); else passes++;
    tick();
    for (int k = 1; k <= 4; k++) beat_trunc(k, (k == 4));
    checks++; if (t_ovalid !== 1'b1 || t_ocount !== 3'd4 || t_otrunc !== 1'b0) $display("FAIL last_at_max got valid=%0b count=%0d trunc=%0b want 1/4/0", t_ovalid, t_ocount, t_otrunc); else passes++;
    tick();
  endtask

  task automatic test_back_to_back();
    i_oready = 0;
    beat_int(3, 0);
    i_valid = 1; i_data = 4; i_last = 1;
    tick();
    i_data = 9;
    checks++; if (i_ovalid !== 1'b1 || i_odata !== 7 || i_ocount !== 5'd2) $display("FAIL bp_rise got valid=%0b data=%0d count=%0d want 1/7/2", i_ovalid, i_odata, i_ocount); else passes++;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (i_ovalid !== 1'b1 || i_ready !== 1'b0 || i_odata !== 7 || i_ocount !== 5'd2)
        $display("FAIL bp_hold_%0d got valid=%0b ready=%0b data=%0d count=%0d want 1/0/7/2", c, i_ovalid, i_ready, i_odata, i_ocount);
      else passes++;
    end
    i_oready = 1;
    tick();
    checks++; if (i_ovalid !== 1'b0 || i_ready !== 1'b1) $display("FAIL bp_handshake got valid=%0b ready=%0b want 0/1", i_ovalid, i_ready); else passes++;
    tick();
    i_valid = 0; i_last = 0;
    checks++; if (i_ovalid !== 1'b1 || i_odata !== 9 || i_ocount !== 5'd1) $display("FAIL bp_next got valid=%0b data=%0d count=%0d want 1/9/1", i_ovalid, i_odata, i_ocount); else passes++;
    tick();
  endtask

  task automatic test_reset_midframe();
    i_oready = 1;
    beat_int(2, 0);
    beat_int(3, 0);
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++; if (i_ovalid !== 1'b0 || i_ready !== 1'b1) $display("FAIL mid_reset got valid=%0b ready=%0b want 0/1", i_ovalid, i_ready); else passes++;
    checks++; if (i_odata !== 0 || i_ocount !== 5'd0 || i_otrunc !== 1'b0) $display("FAIL mid_reset_out got data=%0d count=%0d trunc=%0b want 0/0/0", i_odata, i_ocount, i_otrunc); else passes++;
    beat_int(6, 1);
    checks++; if (i_ovalid !== 1'b1 || i_odata !== 6 || i_ocount !== 5'd1) $display("FAIL mid_reset_next got valid=%0b data=%0d count=%0d want 1/6/1", i_ovalid, i_odata, i_ocount); else passes++;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_int_frame();
    test_real_frame();
    test_wrap();
    test_trunc();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sum_accum.md
# sum_accum

Streaming accumulator that sits directly downstream of `sum` and consumes its `result` stream. It adds a frame of DTYPE values, delimited by `in_last`, into one total and presents that total on a valid/ready output. It uses the same type parameter as `sum`, so integral, 4-state vector and `shortreal` instances follow the same arithmetic rules. A per-frame beat limit (`MAX_LEN`) bounds frame length and flags truncated frames.

## Interface
- `DTYPE`, `int`: element and accumulator type; all arithmetic is performed in DTYPE.
- `MAX_LEN`, `16`: maximum beats per frame, with 1 ≤ MAX_LEN ≤ 255.
- `CW`, `$clog2(MAX_LEN+1)`: width of the beat counter. This is a localparam.

- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  DTYPE  operand, normally `sum.result`.
- `in_last`  in  1  marks the final beat of a frame; qualified by the input handshake.
- `out_valid`  out  1  frame total available.
- `out_ready`  in  1  consumer accepts the total.
- `out_data`  out  DTYPE  frame total.
- `out_count`  out  CW  number of beats in the frame, 1..MAX_LEN.
- `out_trunc`  out  1  frame was closed by MAX_LEN, not by `in_last`.

## Operation
- The FSM has three states:
  - IDLE: no frame is open.
  - ACCUM: a frame is open.
  - HOLD: a total is being presented.
- `in_ready` is `(state != HOLD)` and is driven combinationally from the registered state.
- A beat is accepted when `in_valid && in_ready`.
- Beat accepted in IDLE: `acc <= in_data` (load, no add) and `cnt <= 1`.
- Beat accepted in ACCUM: `acc <= acc + in_data` and `cnt <= cnt + 1`.
- Next state after an accepted beat:
  - HOLD if `in_last` is set, or if the new `cnt` equals MAX_LEN.
  - Otherwise ACCUM.
- On entering HOLD, capture the outputs:
  - `out_data <= ` new acc.
  - `out_count <= ` new cnt.
  - `out_trunc <= !in_last`.
- HOLD: `out_valid` = 1. When `out_valid && out_ready`, go to IDLE on the next edge, then drop `out_valid`.
- `out_data`, `out_count` and `out_trunc` are held stable while `out_valid` = 1.
- Arithmetic is native DTYPE `+`:
  - Integral types wrap modulo 2^width.
  - `shortreal` uses IEEE single rounding.
  - X/Z propagate per 4-state rules.
  - No saturation, no overflow flag.
- No `in_valid` beat in IDLE or ACCUM: no state change. An open frame waits indefinitely.
- `in_last` on the MAX_LEN-th beat: frame closes normally and `out_trunc` = 0.

## Timing
- Reset (`rst_n` = 0 at an edge) sets:
  - state = IDLE
  - `acc` = DTYPE'(0)
  - `cnt` = 0
  - `out_valid` = 0
  - `out_data` = DTYPE'(0)
  - `out_count` = 0
  - `out_trunc` = 0
- Reset also gives `in_ready` = 1 from the cycle after reset.
- Reset has priority over every other event. Reset mid-frame or during HOLD discards the frame with no output.
- Latency: closing beat accepted at edge T → `out_valid` = 1 from T until the output handshake edge.
- Output handshake at edge H → `out_valid` = 0 and `in_ready` = 1 after H. The earliest next beat is accepted at H+1 cycle.
- Minimum frame period is N + 1 cycles for an N-beat frame when `out_ready` is held high.
- `in_ready` falls in the same cycle `out_valid` rises, so no beat is accepted in HOLD.
- Upstream must hold `in_data`/`in_last` stable while `in_valid && !in_ready`.
- `out_ready` asserted while `out_valid` = 0 has no effect.

## Test plan
- DTYPE=int. Frame 2, −5, 7 with `in_last` on 7, `out_ready` = 1 → `out_valid` 1 cycle after the third beat, `out_data` = 4, `out_count` = 3, `out_trunc` = 0.
- DTYPE=shortreal. Frame 1.0, 2.5 (last) → `out_data` = 3.5, `out_count` = 2. Second case: single-beat frame −0.75 (last) → `out_data` = −0.75, `out_count` = 1.
- DTYPE=reg[3:0]. Frame 10, 8 (last) → `out_data` = 2 (wrap), `out_count` = 2. Frame 15, 15, 15 (last) → `out_data` = 13.
- MAX_LEN=4, DTYPE=int. Stream 1, 2, 3, 4, 5 with no `in_last` → after the 4th beat `out_data` = 10, `out_count` = 4, `out_trunc` = 1. `in_ready` = 0 holds back beat 5. After the output handshake, beat 5 starts a new frame.
- Backpressure. `out_ready` = 0 for 3 cycles after `out_valid` rises, with `in_valid` held high → `out_data`/`out_count` stable, `in_ready` = 0 throughout, no beat lost. Handshake on the 4th cycle, next beat accepted the cycle after.
- Reset mid-frame. Beats 2, 3 accepted, then `rst_n` = 0 for one edge → all outputs at reset values. Next frame 6 (last) → `out_data` = 6, `out_count` = 1.
